// File: rtl/arb_mux.sv
// arb_mux: N-channel arbiter feeding a single-entry registered output stage.
// Round-robin (RR=1) or fixed lowest-index priority (RR=0) grant selection.
module arb_mux #(
   parameter int N     = 4,
   parameter int WIDTH = 32,
   parameter int RR    = 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [N-1:0]                in_valid,
   input  logic [N-1:0][WIDTH-1:0]     in_data,
   output logic [N-1:0]                in_ready,
   output logic                        out_valid,
   output logic [WIDTH-1:0]            out_data,
   output logic [$clog2(N)-1:0]        out_src,
   input  logic                        out_ready
);

   localparam int SW = $clog2(N);

   logic [SW-1:0] ptr;
   logic [SW-1:0] start;
   logic [SW-1:0] grant_idx;
   logic [SW-1:0] ptr_next;
   logic          grant_found;
   logic          load_en;
   logic          accept;

   // Fixed priority always searches from channel 0; ptr stays at 0 in that mode.
   assign start   = (RR != 0) ? ptr : '0;
   assign load_en = !out_valid || out_ready;
   assign accept  = grant_found && load_en && !reset;
   assign ptr_next = (grant_idx == SW'(N - 1)) ? '0 : grant_idx + SW'(1);

   // Find the first asserted request at or after start, wrapping modulo N.
   always_comb begin
      int          idx;
      logic [SW-1:0] idx_s;
      grant_found = 1'b0;
      grant_idx   = '0;
      idx         = 0;
      idx_s       = '0;
      for (int k = 0; k < N; k++) begin
         idx = int'(start) + k;
         if (idx >= N) idx = idx - N;
         idx_s = SW'(idx);
         if (!grant_found && in_valid[idx_s]) begin
            grant_found = 1'b1;
            grant_idx   = idx_s;
         end
      end
   end

   // One-hot accept for the granted channel only when the output stage can load.
   always_comb begin
      in_ready = '0;
      if (accept) in_ready[grant_idx] = 1'b1;
   end

   // Output entry and round-robin pointer; a load and a drain in the same
   // cycle simply replace the entry so there is no bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
         ptr       <= '0;
      end else begin
         if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data[grant_idx];
            out_src   <= grant_idx;
            if (RR != 0) ptr <= ptr_next;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
